multicycle_control_fsm: RTL

- Main sequencing FSM for the 16-bit TSC multicycle CPU.
- Drives alu_op and the other datapath control strobes; the ALU control unit consumes alu_op together with the IR.
- Decodes opcode and funct from the IR and steps through IF/ID/EX/MEM/WB with a memory-ready handshake.
- Pulses inst_done once per retired instruction and holds the CPU in HALT after HLT.

---
 rtl/multicycle_control_fsm.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Main sequencing FSM for the 16-bit TSC multicycle CPU.
// Outputs are decoded combinationally from the current state, opcode, funct and mem_ready.
//
// state | meaning
// IF    | fetch instruction, PC <= PC+1 once memory is ready
// ID    | decode, branch target into ALUOut, retire jumps/WWD/HLT/NOP
// EX    | ALU operation or branch resolve
// MEM   | data memory access for LWD/SWD
// WB    | register file write-back
// HALT  | sticky halt until reset
module multicycle_control_fsm #(
    parameter logic [3:0] OPC_RTYPE = 4'd15,
    parameter logic [5:0] FN_HLT    = 6'd29,
    parameter logic [5:0] FN_WWD    = 6'd28
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] opcode,
    input  logic [5:0] funct,
    input  logic       bcond,
    input  logic       mem_ready,
    output logic       alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_update,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       output_active,
    output logic       inst_done,
    output logic       is_halted,
    output logic [2:0] state
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [3:0] OPC_ADI = 4'd4;
    localparam logic [3:0] OPC_ORI = 4'd5;
    localparam logic [3:0] OPC_LHI = 4'd6;
    localparam logic [3:0] OPC_LWD = 4'd7;
    localparam logic [3:0] OPC_SWD = 4'd8;
    localparam logic [3:0] OPC_JMP = 4'd9;
    localparam logic [3:0] OPC_JAL = 4'd10;
    localparam logic [5:0] FN_JPR  = 6'd25;
    localparam logic [5:0] FN_JRL  = 6'd26;

    logic [2:0] state_q, next_state;

    logic is_branch, is_rtype, is_ralu, is_jpr, is_jrl, is_wwd, is_hlt;
    logic is_adi, is_ori, is_lhi, is_lwd, is_swd, is_jmp, is_jal, is_undef;

    always_comb begin
        is_branch = (opcode <= 4'd3);
        is_rtype  = (opcode == OPC_RTYPE);
        is_ralu   = is_rtype && (funct <= 6'd7);
        is_jpr    = is_rtype && (funct == FN_JPR);
        is_jrl    = is_rtype && (funct == FN_JRL);
        is_wwd    = is_rtype && (funct == FN_WWD);
        is_hlt    = is_rtype && (funct == FN_HLT);
        is_adi    = (opcode == OPC_ADI);
        is_ori    = (opcode == OPC_ORI);
        is_lhi    = (opcode == OPC_LHI);
        is_lwd    = (opcode == OPC_LWD);
        is_swd    = (opcode == OPC_SWD);
        is_jmp    = (opcode == OPC_JMP);
        is_jal    = (opcode == OPC_JAL);
        is_undef  = !(is_branch || is_ralu || is_jpr || is_jrl || is_wwd || is_hlt ||
                      is_adi || is_ori || is_lhi || is_lwd || is_swd || is_jmp || is_jal);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IF;
        else          state_q <= next_state;
    end

    logic       c_alu_op, c_src_a, c_i_or_d, c_mem_read, c_mem_write, c_ir_write;
    logic       c_reg_write, c_out_act, c_done, c_halted, c_pc_write, c_pc_write_cond;
    logic [1:0] c_src_b, c_pc_source, c_reg_dst, c_mem_to_reg;

    always_comb begin
        next_state      = state_q;
        c_alu_op        = 1'b0;
        c_src_a         = 1'b0;
        c_src_b         = 2'd0;
        c_pc_source     = 2'd0;
        c_pc_write      = 1'b0;
        c_pc_write_cond = 1'b0;
        c_i_or_d        = 1'b0;
        c_mem_read      = 1'b0;
        c_mem_write     = 1'b0;
        c_ir_write      = 1'b0;
        c_reg_write     = 1'b0;
        c_reg_dst       = 2'd0;
        c_mem_to_reg    = 2'd0;
        c_out_act       = 1'b0;
        c_done          = 1'b0;
        c_halted        = 1'b0;
        case (state_q)
            S_IF: begin
                c_mem_read = 1'b1;
                if (mem_ready) begin
                    c_ir_write = 1'b1;
                    c_pc_write = 1'b1;
                    c_src_b    = 2'd1;
                    next_state = S_ID;
                end
            end
            S_ID: begin
                c_src_b = 2'd2;
                if (is_jmp || is_jal || is_jpr || is_jrl) begin
                    c_pc_write  = 1'b1;
                    c_pc_source = (is_jmp || is_jal) ? 2'd2 : 2'd3;
                    c_done      = 1'b1;
                    next_state  = S_IF;
                    if (is_jal || is_jrl) begin
                        c_reg_write  = 1'b1;
                        c_reg_dst    = 2'd2;
                        c_mem_to_reg = 2'd2;
                    end
                end else if (is_wwd || is_undef) begin
                    c_out_act  = is_wwd;
                    c_done     = 1'b1;
                    next_state = S_IF;
                end else if (is_hlt) begin
                    c_done     = 1'b1;
                    next_state = S_HALT;
                end else begin
                    next_state = S_EX;
                end
            end
            S_EX: begin
                c_src_a    = 1'b1;
                next_state = S_WB;
                if (is_branch) begin
                    c_pc_source     = 2'd1;
                    c_pc_write_cond = 1'b1;
                    c_done          = 1'b1;
                    next_state      = S_IF;
                end else if (is_adi || is_lwd || is_swd) begin
                    c_alu_op = 1'b1;
                    c_src_b  = 2'd2;
                    if (is_lwd || is_swd) next_state = S_MEM;
                end else if (is_ori || is_lhi) begin
                    c_alu_op = 1'b1;
                    c_src_b  = 2'd3;
                end else if (is_ralu) begin
                    c_alu_op = 1'b1;
                end else begin
                    next_state = S_IF;
                end
            end
            S_MEM: begin
                c_i_or_d    = 1'b1;
                c_mem_read  = is_lwd;
                c_mem_write = is_swd;
                if (mem_ready) begin
                    if (is_lwd) begin
                        next_state = S_WB;
                    end else begin
                        c_done     = is_swd;
                        next_state = S_IF;
                    end
                end
            end
            S_WB: begin
                c_reg_write  = 1'b1;
                c_done       = 1'b1;
                c_reg_dst    = is_ralu ? 2'd1 : 2'd0;
                c_mem_to_reg = is_lwd ? 2'd1 : 2'd0;
                next_state   = S_IF;
            end
            S_HALT: begin
                c_halted = 1'b1;
            end
            default: next_state = S_IF;
        endcase
    end

    // Gate with reset_n so an asserted reset silences every strobe immediately.
    assign alu_op        = reset_n & c_alu_op;
    assign alu_src_a     = reset_n & c_src_a;
    assign alu_src_b     = {2{reset_n}} & c_src_b;
    assign pc_source     = {2{reset_n}} & c_pc_source;
    assign pc_update     = reset_n & (c_pc_write | (c_pc_write_cond & bcond));
    assign i_or_d        = reset_n & c_i_or_d;
    assign mem_read      = reset_n & c_mem_read;
    assign mem_write     = reset_n & c_mem_write;
    assign ir_write      = reset_n & c_ir_write;
    assign reg_write     = reset_n & c_reg_write;
    assign reg_dst       = {2{reset_n}} & c_reg_dst;
    assign mem_to_reg    = {2{reset_n}} & c_mem_to_reg;
    assign output_active = reset_n & c_out_act;
    assign inst_done     = reset_n & c_done;
    assign is_halted     = reset_n & c_halted;
    assign state         = {3{reset_n}} & state_q;

endmodule
